mvtr_mon: RTL and testbench

MVTR_MON -- requirements
Module: mvtr_mon

---
 rtl/mvtr_mon.sv | 146 ++++++++++++++
 tb/tb_mvtr_mon.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mvtr_mon.sv
// M-way bitwise majority voter with per-channel error counters and sticky faults.
// Define MVTR_MON_AUTO_MASK_EN to enable auto-masking of channels that reach THR.
module mvtr_mon #(
    parameter int M   = 3,
    parameter int N   = 4,
    parameter int CW  = 8,
    parameter int THR = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [M*N-1:0]       vtr_i,
    input  logic                 valid_i,
    input  logic [M-1:0]         mask_i,
    input  logic                 clr_i,
    input  logic [$clog2(M)-1:0] cnt_sel_i,
    output logic [N-1:0]         vtr_o,
    output logic                 valid_o,
    output logic                 warn_o,
    output logic                 tie_o,
    output logic [M-1:0]         fault_o,
    output logic [M-1:0]         mask_o,
    output logic [CW-1:0]        cnt_o
);

    logic [M-1:0]  amask;
    logic [M-1:0]  act;
    logic [N-1:0]  vote;
    logic          tie;
    logic [M-1:0]  dis;
    int            act_n;
    int            ones;

    logic [N-1:0]  vtr_d, vtr_q;
    logic          valid_d, valid_q;
    logic          warn_d, warn_q;
    logic          tie_d, tie_q;
    logic [M-1:0]  fault_d, fault_q;
    logic [CW-1:0] cnt_d [M];
    logic [CW-1:0] cnt_q [M];

    assign mask_o = mask_i | amask;
    assign act    = ~mask_o;

    always_comb begin
        act_n = 0;
        ones  = 0;
        for (int h = 0; h < M; h++) act_n += int'(act[h]);
        tie  = (act_n == 0);
        vote = '0;
        for (int b = 0; b < N; b++) begin
            ones = 0;
            for (int h = 0; h < M; h++) ones += int'(act[h] & vtr_i[h*N+b]);
            vote[b] = (2 * ones > act_n);
            if (2 * ones == act_n) tie = 1'b1;
        end
        dis = '0;
        for (int h = 0; h < M; h++) dis[h] = act[h] && (vtr_i[h*N +: N] != vote);
    end

    always_comb begin
        vtr_d   = vtr_q;
        warn_d  = warn_q;
        tie_d   = tie_q;
        valid_d = valid_i;
        if (valid_i) begin
            vtr_d  = vote;
            warn_d = |dis;
            tie_d  = tie;
        end
        fault_d = fault_q;
        for (int h = 0; h < M; h++) cnt_d[h] = cnt_q[h];
        // clear wins over a same-cycle increment
        if (clr_i) begin
            fault_d = '0;
            for (int h = 0; h < M; h++) cnt_d[h] = '0;
        end else if (valid_i) begin
            fault_d = fault_q | dis;
            for (int h = 0; h < M; h++)
                if (dis[h] && cnt_q[h] != '1) cnt_d[h] = cnt_q[h] + CW'(1);
        end
    end

`ifdef MVTR_MON_AUTO_MASK_EN
    logic [M-1:0] amask_d, amask_q;
    logic [M-1:0] pick;
    logic         found;
    int           left_n;

    always_comb begin
        pick   = '0;
        found  = 1'b0;
        left_n = 0;
        for (int h = 0; h < M; h++) begin
            if (!found && !amask_q[h] && cnt_q[h] >= CW'(THR)) begin
                pick[h] = 1'b1;
                found   = 1'b1;
            end
        end
        // never leave fewer than two voters
        for (int h = 0; h < M; h++) left_n += int'(~(mask_i[h] | amask_q[h] | pick[h]));
        amask_d = amask_q;
        if (clr_i) amask_d = '0;
        else if (found && left_n >= 2) amask_d = amask_q | pick;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) amask_q <= '0;
        else       amask_q <= amask_d;
    end

    assign amask = amask_q;
`else
    assign amask = '0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vtr_q   <= '0;
            valid_q <= 1'b0;
            warn_q  <= 1'b0;
            tie_q   <= 1'b0;
            fault_q <= '0;
            for (int h = 0; h < M; h++) cnt_q[h] <= '0;
        end else begin
            vtr_q   <= vtr_d;
            valid_q <= valid_d;
            warn_q  <= warn_d;
            tie_q   <= tie_d;
            fault_q <= fault_d;
            for (int h = 0; h < M; h++) cnt_q[h] <= cnt_d[h];
        end
    end

    always_comb begin
        cnt_o = '0;
        for (int h = 0; h < M; h++)
            if (int'(cnt_sel_i) == h) cnt_o = cnt_q[h];
    end

    assign vtr_o   = vtr_q;
    assign valid_o = valid_q;
    assign warn_o  = warn_q;
    assign tie_o   = tie_q;
    assign fault_o = fault_q;

endmodule

// File: tb/tb_mvtr_mon.sv
// Bench for mvtr_mon: directed steps plus random samples against a vote model.
// Auto-mask steps run only when MVTR_MON_AUTO_MASK_EN is defined.
module tb_mvtr_mon;

    localparam int M   = 3;
    localparam int N   = 4;
    localparam int CW  = 8;
    localparam int THR = 16;
    localparam int SW  = $clog2(M);

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [M*N-1:0] vtr_i;
    logic           valid_i;
    logic [M-1:0]   mask_i;
    logic           clr_i;
    logic [SW-1:0]  cnt_sel_i;
    logic [N-1:0]   vtr_o;
    logic           valid_o;
    logic           warn_o;
    logic           tie_o;
    logic [M-1:0]   fault_o;
    logic [M-1:0]   mask_o;
    logic [CW-1:0]  cnt_o;

    mvtr_mon #(.M(M), .N(N), .CW(CW), .THR(THR)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .vtr_i    (vtr_i),
        .valid_i  (valid_i),
        .mask_i   (mask_i),
        .clr_i    (clr_i),
        .cnt_sel_i(cnt_sel_i),
        .vtr_o    (vtr_o),
        .valid_o  (valid_o),
        .warn_o   (warn_o),
        .tie_o    (tie_o),
        .fault_o  (fault_o),
        .mask_o   (mask_o),
        .cnt_o    (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int nerr = 0;
    int nchk = 0;

    int           m_cnt [M];
    logic [M-1:0] m_fault;
    logic [M-1:0] m_amask;
    logic [N-1:0] e_vtr;
    logic         e_valid, e_warn, e_tie;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int h = 0; h < M; h++) m_cnt[h] = 0;
        m_fault = '0;
        m_amask = '0;
        e_vtr   = '0;
        e_valid = 1'b0;
        e_warn  = 1'b0;
        e_tie   = 1'b0;
    endtask

    // Predicts the state after the coming edge from the current inputs.
    task automatic model_step();
        logic [M-1:0] act, dis, nxt_am;
        logic [N-1:0] vote;
        logic         tie;
        int           a, ones;
        act  = ~(mask_i | m_amask);
        a    = $countones(act);
        tie  = (a == 0);
        vote = '0;
        for (int b = 0; b < N; b++) begin
            ones = 0;
            for (int h = 0; h < M; h++) if (act[h] && vtr_i[h*N+b]) ones++;
            vote[b] = (2 * ones > a);
            if (2 * ones == a) tie = 1'b1;
        end
        dis = '0;
        for (int h = 0; h < M; h++) dis[h] = act[h] && (vtr_i[h*N +: N] != vote);
        nxt_am = m_amask;
`ifdef MVTR_MON_AUTO_MASK_EN
        for (int h = 0; h < M; h++) begin
            if (!m_amask[h] && m_cnt[h] >= THR) begin
                logic [M-1:0] trial;
                trial = m_amask;
                trial[h] = 1'b1;
                if ($countones(~(mask_i | trial)) >= 2) nxt_am = trial;
                break;
            end
        end
`endif
        e_valid = valid_i;
        if (valid_i) begin
            e_vtr  = vote;
            e_warn = |dis;
            e_tie  = tie;
        end
        if (clr_i) begin
            for (int h = 0; h < M; h++) m_cnt[h] = 0;
            m_fault = '0;
            m_amask = '0;
        end else begin
            if (valid_i) begin
                for (int h = 0; h < M; h++)
                    if (dis[h] && m_cnt[h] < (1 << CW) - 1) m_cnt[h]++;
                m_fault = m_fault | dis;
            end
            m_amask = nxt_am;
        end
    endtask

    task automatic check_all(input string tag);
        int ec;
        ec = 0;
        if (int'(cnt_sel_i) < M) ec = m_cnt[cnt_sel_i];
        chk({tag, ".vtr"},   32'(vtr_o),   32'(e_vtr));
        chk({tag, ".valid"}, 32'(valid_o), 32'(e_valid));
        chk({tag, ".warn"},  32'(warn_o),  32'(e_warn));
        chk({tag, ".tie"},   32'(tie_o),   32'(e_tie));
        chk({tag, ".fault"}, 32'(fault_o), 32'(m_fault));
        chk({tag, ".mask"},  32'(mask_o),  32'(mask_i | m_amask));
        chk({tag, ".cnt"},   32'(cnt_o),   32'(ec));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_i     = 1'b1;
        vtr_i     = '0;
        valid_i   = 1'b0;
        mask_i    = '0;
        clr_i     = 1'b0;
        cnt_sel_i = '0;
        model_reset();
        @(posedge clk_i);
        #1;
        check_all("reset");
        rst_i = 1'b0;

        vtr_i   = {4'hA, 4'hA, 4'hA};
        valid_i = 1'b1;
        step("all_a");
        chk("all_a.const_vtr", 32'(vtr_o), 32'hA);
        chk("all_a.const_warn", 32'(warn_o), 32'h0);

        cnt_sel_i = 2'd1;
        vtr_i     = {4'hA, 4'h5, 4'hA};
        step("ch1_first");
        chk("ch1_first.const_cnt", 32'(cnt_o), 32'd1);
        chk("ch1_first.const_fault", 32'(fault_o), 32'b010);
        for (int i = 0; i < 259; i++) step("ch1_err");
`ifndef MVTR_MON_AUTO_MASK_EN
        chk("ch1_sat.const_cnt", 32'(cnt_o), 32'd255);
        chk("ch1_sat.const_warn", 32'(warn_o), 32'h1);
`endif

        valid_i = 1'b0;
        vtr_i   = 12'h3C5;
        step("hold");
        clr_i = 1'b1;
        step("clr");
        clr_i = 1'b0;

        valid_i = 1'b1;
        mask_i  = 3'b100;
        vtr_i   = {4'h3, 4'h0, 4'hF};
        step("tie_two");
        chk("tie_two.const_tie", 32'(tie_o), 32'h1);
        chk("tie_two.const_vtr", 32'(vtr_o), 32'h0);
        mask_i = 3'b111;
        step("tie_none");
        chk("tie_none.const_tie", 32'(tie_o), 32'h1);
        mask_i = '0;

`ifdef MVTR_MON_AUTO_MASK_EN
        clr_i = 1'b1;
        step("am_clr");
        clr_i     = 1'b0;
        cnt_sel_i = 2'd2;
        vtr_i     = {4'h5, 4'hA, 4'hA};
        for (int i = 0; i < 16; i++) step("am_ch2");
        vtr_i = {4'hA, 4'hA, 4'hA};
        step("am_ch2_mask");
        chk("am_ch2_mask.const", 32'(mask_o), 32'b100);
        vtr_i = {4'h5, 4'hA, 4'hA};
        step("am_ch2_quiet");
        chk("am_ch2_quiet.const_warn", 32'(warn_o), 32'h0);

        clr_i = 1'b1;
        step("am_clr2");
        clr_i = 1'b0;
        vtr_i = {4'hE, 4'hA, 4'hB};
        for (int i = 0; i < 16; i++) step("am_both");
        vtr_i = {4'hA, 4'hA, 4'hA};
        step("am_both_m1");
        chk("am_both_m1.const", 32'(mask_o), 32'b001);
        step("am_both_m2");
        chk("am_both_m2.const", 32'(mask_o), 32'b001);
`endif

        cnt_sel_i = 2'd1;
        vtr_i     = {4'hA, 4'h5, 4'hA};
        step("pre_clr");
        clr_i = 1'b1;
        step("clr_dis");
        chk("clr_dis.const_fault", 32'(fault_o), 32'h0);
        chk("clr_dis.const_cnt", 32'(cnt_o), 32'h0);
        chk("clr_dis.const_vtr", 32'(vtr_o), 32'hA);
        clr_i = 1'b0;

        for (int i = 0; i < 300; i++) begin
            vtr_i     = 12'($urandom);
            valid_i   = ($urandom_range(0, 3) != 0);
            mask_i    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            clr_i     = ($urandom_range(0, 31) == 0);
            cnt_sel_i = 2'($urandom_range(0, 3));
            step("rand");
        end

        valid_i   = 1'b1;
        mask_i    = '0;
        clr_i     = 1'b0;
        cnt_sel_i = 2'd0;
        vtr_i     = {4'h6, 4'h6, 4'h9};
        step("pre_rst");
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        chk("rst_async.const_vtr", 32'(vtr_o), 32'h0);
        @(posedge clk_i);
        #1;
        check_all("rst_hold");
        rst_i = 1'b0;
        vtr_i = {4'hA, 4'hA, 4'hA};
        step("resume");
        chk("resume.const_vtr", 32'(vtr_o), 32'hA);
        chk("resume.const_valid", 32'(valid_o), 32'h1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
